// File: rtl/key_expand_seq.sv
// key_expand_seq: streaming AES key schedule generator (FIPS-197 KeyExpansion).
// Emits w[0..LAST] one word per handshake while holding only the last Nk words.
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   start, key_in   - request expansion of key_in (w[0] in the top 32 bits), taken in IDLE only
//   w_valid/w_ready - valid/ready handshake for the schedule word
//   w_out, w_idx    - schedule word w[w_idx]
//   busy, done      - run in progress; one-cycle pulse after the final word is accepted
//   sub_in, sub_out - word sent to an external combinational SubWord unit and its result
module key_expand_seq #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [31:0]         w_out,
    output logic [5:0]          w_idx,
    output logic                busy,
    output logic                done,
    output logic [31:0]         sub_in,
    input  logic [31:0]         sub_out
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int LAST = 4 * (NR + 1) - 1;
    localparam logic [5:0] LAST_IDX = 6'(LAST);
    localparam logic [2:0] NK_M1 = 3'(NK - 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("key_expand_seq: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {IDLE, KEYOUT, GEN} state_t;

    state_t              state_q, state_d;
    // win_q[NK-1] is the oldest word w[i-Nk], win_q[0] the newest w[i-1]
    logic [NK-1:0][31:0] win_q, win_d;
    logic [5:0]          idx_q, idx_d;
    // pos_q tracks i mod Nk without a divider
    logic [2:0]          pos_q, pos_d;
    logic [7:0]          rcon_q, rcon_d;
    logic                done_q, done_d;
    logic [31:0]         oldest, newest, temp;
    logic                is_rot, is_sub, hs;

    always_comb begin
        oldest  = win_q[NK-1];
        newest  = win_q[0];
        is_rot  = pos_q == 3'd0;
        is_sub  = (NK == 8) && (pos_q == 3'd4);
        sub_in  = is_rot ? {newest[23:0], newest[31:24]} : newest;
        temp    = is_rot ? (sub_out ^ {rcon_q, 24'h0}) : is_sub ? sub_out : newest;
        w_valid = state_q != IDLE;
        w_out   = (state_q == GEN) ? (oldest ^ temp) : (state_q == KEYOUT) ? oldest : 32'h0;
        hs      = w_valid & w_ready;
    end

    assign busy  = w_valid;
    assign done  = done_q;
    assign w_idx = idx_q;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = KEYOUT;
                    win_d   = key_in;
                    idx_d   = 6'd0;
                    pos_d   = 3'd0;
                    rcon_d  = 8'h01;
                end
            end
            default: begin
                if (hs) begin
                    // During KEYOUT the window rotates, so after Nk words it again holds w[0..Nk-1]
                    win_d = {win_q[NK-2:0], w_out};
                    idx_d = idx_q + 6'd1;
                    pos_d = (pos_q == NK_M1) ? 3'd0 : pos_q + 3'd1;
                    if (state_q == KEYOUT && pos_q == NK_M1)
                        state_d = GEN;
                    if (state_q == GEN && is_rot)
                        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    if (state_q == GEN && idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 6'd0;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            idx_q   <= 6'd0;
            pos_q   <= 3'd0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_key_expand_seq.sv
// tb_key_expand_seq: directed checks of key_expand_seq for 128/192/256-bit keys.
module tb_key_expand_seq;
    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] start = 3'b000;
    logic [2:0] rdy = 3'b111;
    logic [127:0] k128 = K128;
    wire  [2:0] wv, bz, dn;
    wire  [2:0][31:0] wo, si, so;
    wire  [2:0][5:0] wi;

    logic [31:0] ref_w [3][60];
    logic [31:0] got [3][60];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [31:0] rot(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    assign so[0] = subw(si[0]);
    assign so[1] = subw(si[1]);
    assign so[2] = subw(si[2]);

    key_expand_seq #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .key_in(k128),
        .w_valid(wv[0]), .w_ready(rdy[0]), .w_out(wo[0]), .w_idx(wi[0]),
        .busy(bz[0]), .done(dn[0]), .sub_in(si[0]), .sub_out(so[0]));

    key_expand_seq #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .key_in(K192),
        .w_valid(wv[1]), .w_ready(rdy[1]), .w_out(wo[1]), .w_idx(wi[1]),
        .busy(bz[1]), .done(dn[1]), .sub_in(si[1]), .sub_out(so[1]));

    key_expand_seq #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .key_in(K256),
        .w_valid(wv[2]), .w_ready(rdy[2]), .w_out(wo[2]), .w_idx(wi[2]),
        .busy(bz[2]), .done(dn[2]), .sub_in(si[2]), .sub_out(so[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expand(input int k, input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) ref_w[k][i] = key[nk*32-1-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = ref_w[k][i-1];
            if (i % nk == 0) begin
                t = subw(rot(t)) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            ref_w[k][i] = t ^ ref_w[k][i-nk];
        end
    endtask

    task automatic run_key(input int k, input int stall, input int start_at, input int rst_at);
        int nk, last, cnt, cyc;
        bit poked;
        nk = (k == 0) ? 4 : (k == 1) ? 6 : 8;
        last = 4 * (nk + 7) - 1;
        cnt = 0;
        cyc = 0;
        poked = 1'b0;
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        while (cnt <= last && cyc < 4000) begin
            rdy[k] = (stall == 0) || ($urandom_range(0, 99) >= stall);
            start[k] = 1'b0;
            k128 = K128;
            if (cnt == start_at && !poked) begin
                start[k] = 1'b1;
                k128 = ~K128;
                poked = 1'b1;
            end
            check("w_valid", 32'(wv[k]), 32'd1);
            check("w_idx", 32'(wi[k]), 32'(cnt));
            check("w_out", wo[k], ref_w[k][cnt]);
            if (cnt >= nk && cnt % nk == 0)
                check("sub_in_rot", si[k], rot(ref_w[k][cnt-1]));
            got[k][cnt] = wo[k];
            if (cnt == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", 32'(wv[k]), 32'd0);
                check("rst_out", wo[k], 32'd0);
                check("rst_idx", 32'(wi[k]), 32'd0);
                check("rst_busy", 32'(bz[k]), 32'd0);
                check("rst_done", 32'(dn[k]), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                start[k] = 1'b0;
                k128 = K128;
                rdy[k] = 1'b1;
                repeat (2) @(negedge clk);
                check("no_resume", 32'(bz[k]), 32'd0);
                return;
            end
            @(posedge clk);
            if (rdy[k]) cnt++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 4000) check("timeout", 32'd0, 32'd1);
        start[k] = 1'b0;
        k128 = K128;
        rdy[k] = 1'b1;
        if (stall == 0) check("valid_cycles", 32'(cyc), 32'(last + 1));
        check("done", 32'(dn[k]), 32'd1);
        check("done_busy", 32'(bz[k]), 32'd0);
        check("done_valid", 32'(wv[k]), 32'd0);
        @(negedge clk);
        check("done_once", 32'(dn[k]), 32'd0);
    endtask

    initial begin
        expand(0, 4, {128'h0, K128});
        expand(1, 6, {64'h0, K192});
        expand(2, 8, K256);
        #12;
        for (int k = 0; k < 3; k++) begin
            check("reset_valid", 32'(wv[k]), 32'd0);
            check("reset_busy", 32'(bz[k]), 32'd0);
            check("reset_done", 32'(dn[k]), 32'd0);
            check("reset_idx", 32'(wi[k]), 32'd0);
            check("reset_out", wo[k], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_key(0, 0, -1, -1);
        check("w128_4", got[0][4], 32'ha0fafe17);
        check("w128_43", got[0][43], 32'hb6630ca6);
        run_key(1, 0, -1, -1);
        check("w192_6", got[1][6], 32'hfe0c91f7);
        check("w192_51", got[1][51], 32'h01002202);
        run_key(2, 0, -1, -1);
        check("w256_8", got[2][8], 32'h9ba35411);
        check("w256_12", got[2][12], 32'ha8b09c1a);
        check("w256_59", got[2][59], 32'h706c631e);
        run_key(0, 40, -1, -1);
        run_key(0, 0, 10, 20);
        run_key(0, 0, -1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
